// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer for the Tomasulo core.
// Hands out ROB IDs at dispatch, captures CDB results, serves operand
// lookups and retires entries in program order onto the commit port.
// A mispredicted branch reaching the head raises a one-cycle flush.
//
// Optional feature macro: ROB_CDB_BYPASS_EN
//   defined   -> operand lookups also see a same-cycle CDB broadcast
//   undefined -> operand lookups reflect stored entry state only
module reorder_buffer #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  // dispatch / allocation
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [ID_W-1:0] alloc_id,
  input  logic [4:0]      alloc_rd,
  input  logic            alloc_has_rd,
  input  logic            alloc_is_branch,
  // common data bus
  input  logic            cdb_valid,
  input  logic [ID_W-1:0] cdb_rob_id,
  input  logic [31:0]     cdb_value,
  input  logic            cdb_mispredict,
  input  logic [31:0]     cdb_target,
  // operand lookups
  input  logic [ID_W-1:0] q1_id,
  input  logic [ID_W-1:0] q2_id,
  output logic            q1_ready,
  output logic            q2_ready,
  output logic [31:0]     q1_value,
  output logic [31:0]     q2_value,
  // commit port
  output logic            commit_we,
  output logic [4:0]      commit_addr,
  output logic [ID_W-1:0] commit_rob_id,
  output logic [31:0]     commit_value,
  output logic            flush,
  output logic [31:0]     flush_pc,
  output logic            empty
);

  localparam int              DEPTH = 2 ** ID_W;
  localparam logic [ID_W:0]   FULL  = (ID_W + 1)'(DEPTH);

  // per-entry state
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] has_rd;
  logic [DEPTH-1:0] is_branch;
  logic [DEPTH-1:0] mispredict;
  logic [4:0]       rd     [DEPTH];
  logic [31:0]      value  [DEPTH];
  logic [31:0]      target [DEPTH];

  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  tail;
  logic [ID_W:0]    count;

  logic alloc_fire;
  logic cdb_fire;
  logic commit_fire;
  logic commit_flush;

  assign alloc_ready  = (count != FULL) && !flush;
  assign alloc_id     = tail;
  assign empty        = (count == '0);

  assign alloc_fire   = alloc_valid && alloc_ready;
  // Results arriving during the flush pulse belong to squashed producers.
  assign cdb_fire     = cdb_valid && !flush && busy[cdb_rob_id];
  assign commit_fire  = busy[head] && ready[head];
  assign commit_flush = commit_fire && mispredict[head];

  // Payload capture: destination info at allocation, branch outcome on the CDB.
  // NOTE: these fields need no reset; they are only read once busy/ready
  // (which are reset) say the entry holds valid contents.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd[tail]         <= alloc_rd;
      has_rd[tail]     <= alloc_has_rd;
      is_branch[tail]  <= alloc_is_branch;
      mispredict[tail] <= 1'b0;
    end
    if (cdb_fire) begin
      mispredict[cdb_rob_id] <= cdb_mispredict && is_branch[cdb_rob_id];
      target[cdb_rob_id]     <= cdb_target;
    end
  end

  // Control state, values seen by the read ports, and the registered commit port.
  // NOTE: value[] is reset because the read ports expose it directly and
  // must show zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      ready         <= '0;
      for (int i = 0; i < DEPTH; i++) value[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      commit_we     <= 1'b0;
      commit_addr   <= '0;
      commit_rob_id <= '0;
      commit_value  <= '0;
      flush         <= 1'b0;
      flush_pc      <= '0;
    end else begin
      // commit port and flush are single-cycle pulses
      commit_we     <= 1'b0;
      commit_addr   <= '0;
      commit_rob_id <= '0;
      commit_value  <= '0;
      flush         <= 1'b0;
      flush_pc      <= '0;

      if (cdb_fire) begin
        ready[cdb_rob_id] <= 1'b1;
        value[cdb_rob_id] <= cdb_value;
      end

      if (alloc_fire) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
      end

      if (commit_fire) begin
        commit_we     <= has_rd[head] && (rd[head] != 5'd0);
        commit_addr   <= rd[head];
        commit_rob_id <= head;
        commit_value  <= value[head];
        busy[head]    <= 1'b0;
      end

      if (commit_flush) begin
        // squash everything younger, including any same-cycle allocation
        flush    <= 1'b1;
        flush_pc <= target[head];
        busy     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (commit_fire) head <= head + 1'b1;
        if (alloc_fire)  tail <= tail + 1'b1;
        count <= count + (ID_W + 1)'(alloc_fire) - (ID_W + 1)'(commit_fire);
      end
    end
  end

  // Operand lookups from stored state, optionally bypassing the live CDB.
  always_comb begin
    q1_ready = ready[q1_id];
    q1_value = value[q1_id];
    q2_ready = ready[q2_id];
    q2_value = value[q2_id];
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_rob_id == q1_id)) begin
      q1_ready = 1'b1;
      q1_value = cdb_value;
    end
    if (cdb_valid && (cdb_rob_id == q2_id)) begin
      q2_ready = 1'b1;
      q2_value = cdb_value;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized scoreboard bench for reorder_buffer.
// A program-order queue models the buffer; expected commit/flush events are
// queued by the driver and popped by an independent monitor.
module tb_reorder_buffer;

  localparam int ID_W  = 4;
  localparam int DEPTH = 16;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [ID_W-1:0] alloc_id;
  logic [4:0]      alloc_rd;
  logic            alloc_has_rd;
  logic            alloc_is_branch;
  logic            cdb_valid;
  logic [ID_W-1:0] cdb_rob_id;
  logic [31:0]     cdb_value;
  logic            cdb_mispredict;
  logic [31:0]     cdb_target;
  logic [ID_W-1:0] q1_id;
  logic [ID_W-1:0] q2_id;
  logic            q1_ready;
  logic            q2_ready;
  logic [31:0]     q1_value;
  logic [31:0]     q2_value;
  logic            commit_we;
  logic [4:0]      commit_addr;
  logic [ID_W-1:0] commit_rob_id;
  logic [31:0]     commit_value;
  logic            flush;
  logic [31:0]     flush_pc;
  logic            empty;

  reorder_buffer #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_rd(alloc_rd), .alloc_has_rd(alloc_has_rd), .alloc_is_branch(alloc_is_branch),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_we(commit_we), .commit_addr(commit_addr), .commit_rob_id(commit_rob_id),
    .commit_value(commit_value), .flush(flush), .flush_pc(flush_pc), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: in-flight instructions in program order
  typedef struct {
    int          id;
    logic [4:0]  rd;
    bit          has_rd;
    bit          br;
    bit          done;
    logic [31:0] val;
    bit          mp;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    int          id;
    logic [31:0] val;
    bit          fl;
    logic [31:0] pc;
  } exp_t;

  ent_t rob[$];
  exp_t sb[$];
  int   tail_id;
  bit   flushing;
  bit   mon_on;

  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // operand lookup expectation; only checked where the model defines it
  task automatic chk_q(input string nm, input logic [3:0] qid,
                       input logic rdy, input logic [31:0] val);
    bit          known = 1'b0;
    bit          d     = 1'b0;
    logic [31:0] v     = '0;
    if (BYP && cdb_valid && cdb_rob_id == qid) begin
      known = 1'b1; d = 1'b1; v = cdb_value;
    end else begin
      foreach (rob[i]) if (rob[i].id == int'(qid)) begin
        known = 1'b1; d = rob[i].done; v = rob[i].val;
      end
    end
    if (known) begin
      check({nm, "_ready"}, 32'(rdy), 32'(d));
      if (d) check({nm, "_value"}, val, v);
    end
  endtask

  // monitor: pops an expected event whenever the commit port shows activity
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on && (commit_we || flush)) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", {30'd0, commit_we, flush}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("commit_we", 32'(commit_we), 32'(e.we));
          check("flush", 32'(flush), 32'(e.fl));
          if (e.we) begin
            check("commit_addr", 32'(commit_addr), 32'(e.addr));
            check("commit_rob_id", 32'(commit_rob_id), 32'(e.id));
            check("commit_value", commit_value, e.val);
          end
          if (e.fl) check("flush_pc", flush_pc, e.pc);
        end
      end
    end
  end

  // one clock of stimulus: randomize, check combinational outputs, step model
  task automatic cycle(input int pa, input int pc, input int pm, input bit do_rst);
    int   und[$];
    ent_t c;
    exp_t e;
    bit   afire;
    bit   mpf;
    @(negedge clk);
    #1;
    rst             = do_rst;
    alloc_valid     = !do_rst && ($urandom_range(99) < pa);
    alloc_rd        = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
    alloc_has_rd    = ($urandom_range(3) != 0);
    alloc_is_branch = ($urandom_range(3) == 0);
    und.delete();
    foreach (rob[i]) if (!rob[i].done) und.push_back(rob[i].id);
    cdb_valid       = 1'b0;
    cdb_rob_id      = 4'($urandom_range(15));
    if (!do_rst && $urandom_range(99) < pc) begin
      cdb_valid = 1'b1;
      if (und.size() > 0 && $urandom_range(9) != 0)
        cdb_rob_id = 4'(und[$urandom_range(und.size() - 1)]);
    end
    cdb_value      = $urandom;
    cdb_mispredict = ($urandom_range(99) < pm);
    cdb_target     = $urandom & 32'hffff_fffc;
    q1_id          = ($urandom_range(1) == 0) ? cdb_rob_id : 4'($urandom_range(15));
    q2_id          = 4'($urandom_range(15));
    #1;
    if (do_rst) begin
      rob.delete();
      tail_id  = 0;
      flushing = 1'b0;
      return;
    end
    check("alloc_ready", 32'(alloc_ready), 32'(rob.size() < DEPTH && !flushing));
    check("alloc_id", 32'(alloc_id), 32'(tail_id));
    check("empty", 32'(empty), 32'(rob.size() == 0));
    chk_q("q1", q1_id, q1_ready, q1_value);
    chk_q("q2", q2_id, q2_ready, q2_value);

    afire = alloc_valid && rob.size() < DEPTH && !flushing;
    mpf   = 1'b0;
    // retire oldest if it was already complete before this edge
    if (rob.size() > 0 && rob[0].done) begin
      c    = rob.pop_front();
      mpf  = c.mp;
      e.we = c.has_rd && c.rd != 5'd0;
      e.addr = c.rd; e.id = c.id; e.val = c.val; e.fl = c.mp; e.pc = c.tgt;
      if (e.we || e.fl) sb.push_back(e);
    end
    // broadcast lands in a still-live entry only
    if (cdb_valid && !flushing) begin
      foreach (rob[i]) if (rob[i].id == int'(cdb_rob_id)) begin
        rob[i].done = 1'b1;
        rob[i].val  = cdb_value;
        rob[i].mp   = cdb_mispredict && rob[i].br;
        rob[i].tgt  = cdb_target;
      end
    end
    if (mpf) begin
      rob.delete();
      tail_id = 0;
    end else if (afire) begin
      c.id = tail_id; c.rd = alloc_rd; c.has_rd = alloc_has_rd; c.br = alloc_is_branch;
      c.done = 1'b0; c.val = '0; c.mp = 1'b0; c.tgt = '0;
      rob.push_back(c);
      tail_id = (tail_id + 1) % DEPTH;
    end
    flushing = mpf;
  endtask

  // phase table: cycles, alloc %, cdb %, mispredict %
  int ph_n [8] = '{24,  30, 200,  30, 300, 200, 100,  60};
  int ph_a [8] = '{100,  0,  70, 100,  60,  90,  40,   0};
  int ph_c [8] = '{0,   60,  50,   0,  60,  30,  80, 100};
  int ph_m [8] = '{0,    0,   0,   0,   5,   3,  10,   0};

  initial begin
    total = 0; bad = 0; mon_on = 1'b0;
    tail_id = 0; flushing = 1'b0;
    rst = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; alloc_has_rd = 1'b0;
    alloc_is_branch = 1'b0; cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    cdb_mispredict = 1'b0; cdb_target = '0; q1_id = '0; q2_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_alloc_id", 32'(alloc_id), 32'd0);
    check("rst_commit_we", 32'(commit_we), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_q1_ready", 32'(q1_ready), 32'd0);
    check("rst_q1_value", q1_value, 32'd0);
    mon_on = 1'b1;

    for (int p = 0; p < 8; p++) begin
      if (p == 3) cycle(0, 0, 0, 1'b1);  // reset with work in flight
      for (int k = 0; k < ph_n[p]; k++) cycle(ph_a[p], ph_c[p], ph_m[p], 1'b0);
    end
    repeat (3) cycle(0, 0, 0, 1'b0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("final_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
